// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared widths, constants and the one-hot decode helper for the 2-to-4
// decoder block.
//   SEL_W           : width of the select code {a, b}
//   OUT_W           : number of decoded output lines
//   D_INACTIVE_HIGH : all-lines-off pattern in active-high polarity
//   decode_onehot() : select code -> active-high one-hot pattern
package decoder_pkg;

    localparam int SEL_W = 2;
    localparam int OUT_W = 4;

    localparam logic [OUT_W-1:0] D_INACTIVE_HIGH = 4'b0000;

    // Line i is set when the select code equals i; all others stay clear.
    function automatic logic [OUT_W-1:0] decode_onehot(input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (sel == i[SEL_W-1:0]) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_2x4_comb.sv
// decoder_2x4_comb
// Purely combinational select/enable to active-high one-hot decode.
// Ports:
//   en     : decode enable; 0 forces every line off
//   sel    : 2-bit select code, {a, b}
//   onehot : active-high one-hot lines (all zero when disabled)
module decoder_2x4_comb
    import decoder_pkg::*;
(
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] onehot
);

    always_comb begin
        onehot = D_INACTIVE_HIGH;
        if (en) begin
            onehot = decode_onehot(sel);
        end
    end

endmodule

// File: rtl/decoder_2x4.sv
// decoder_2x4
// Registered 2-to-4 line decoder. {a, b} selects one of four output lines;
// the result appears on D one clock after the inputs are sampled.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset; drives D to the inactive pattern
//   en    : decode enable; 0 makes all lines inactive at the next edge
//   a     : select MSB
//   b     : select LSB
//   D     : decoded lines, one-hot (OUT_ACTIVE_LOW = 0) or one-cold (= 1)
module decoder_2x4
    import decoder_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    output logic [OUT_W-1:0] D
);

    // Inactive pattern in the selected output polarity, used on reset.
    localparam logic [OUT_W-1:0] D_INACTIVE =
        OUT_ACTIVE_LOW ? ~D_INACTIVE_HIGH : D_INACTIVE_HIGH;

    logic [SEL_W-1:0] sel;
    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] d_next;

    assign sel = {a, b};

    decoder_2x4_comb u_comb (
        .en     (en),
        .sel    (sel),
        .onehot (onehot)
    );

    // Polarity is applied before the register so D itself never glitches.
    always_comb begin
        d_next = onehot;
        if (OUT_ACTIVE_LOW) begin
            d_next = ~onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D <= D_INACTIVE;
        end else begin
            D <= d_next;
        end
    end

endmodule

// File: tb/tb_decoder_2x4.sv
// tb_decoder_2x4
// Drives an active-high and an active-low build of decoder_2x4 from the
// same inputs and compares both against a reference model (1 << sel).
module tb_decoder_2x4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       a;
    logic       b;
    logic [3:0] d_hi;
    logic [3:0] d_lo;

    int checks   = 0;
    int failures = 0;

    // Expected active-high values, one entry per driven cycle.
    logic [3:0] exp_q[$];

    decoder_2x4 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .b     (b),
        .D     (d_hi)
    );

    decoder_2x4 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .b     (b),
        .D     (d_lo)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [3:0] model_hi(input logic e, input int s);
        int v;
        v = e ? (1 << s) : 0;
        return v[3:0];
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Pop one expected value and compare both builds; on enabled cycles
    // also confirm exactly one line is active.
    task automatic score(input string tag, input logic was_en);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_empty_q"}, 4'hx, 4'h0);
            return;
        end
        e = exp_q.pop_front();
        check_eq({tag, "_hi"}, d_hi, e);
        check_eq({tag, "_lo"}, d_lo, ~e);
        if (was_en) begin
            check_eq({tag, "_onehot"}, 4'($countones(d_hi)), 4'd1);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge: apply inputs, let the rising edge
    // capture them, then score at the following falling edge.
    task automatic step(input string tag, input logic e, input int s);
        en = e;
        {a, b} = 2'(s);
        exp_q.push_back(model_hi(e, s));
        @(posedge clk);
        @(negedge clk);
        score(tag, e);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        {a, b} = 2'd3;

        // Reset held with a live select: outputs stay inactive.
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_hold_hi", d_hi, 4'b0000);
        check_eq("rst_hold_lo", d_lo, 4'b1111);

        // Release; first decode at the next rising edge.
        rst_n = 1'b1;
        step("rst_release", 1'b1, 3);

        // Sweep with wrap-around 3 -> 0.
        for (int i = 0; i < 9; i++) begin
            step("sweep", 1'b1, i % 4);
        end

        // Enable toggle at sel 2.
        step("en_on",  1'b1, 2);
        step("en_off", 1'b0, 2);
        step("en_on2", 1'b1, 2);

        // en falling together with a select change.
        step("en_fall_sel", 1'b0, 1);

        // Asynchronous reset between edges while D = 0010.
        step("pre_async", 1'b1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_hi", d_hi, 4'b0000);
        check_eq("async_rst_lo", d_lo, 4'b1111);
        @(negedge clk);
        check_eq("async_hold_hi", d_hi, 4'b0000);
        rst_n = 1'b1;
        step("post_async", 1'b1, 0);

        // Two select changes inside one cycle: only the last one counts,
        // and D keeps its old value until the edge.
        en = 1'b1;
        {a, b} = 2'd1;
        #1;
        check_eq("glitch_mid", d_hi, 4'b0001);
        step("glitch_edge", 1'b1, 2);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time guard so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
